// File: rtl/game_state_ctrl_if.sv
// Button, collision, tick and game-state signals shared between the sequencer
// and its sources/consumers.
interface game_state_ctrl_if;
  logic        btn_jump;
  logic        btn_reset;
  logic        collision;
  logic        game_tick;
  logic [1:0]  game_state;
  logic [13:0] score;
  logic [13:0] high_score;
  logic        start_pulse;

  modport master (
    output btn_jump, btn_reset, collision, game_tick,
    input  game_state, score, high_score, start_pulse
  );

  modport slave (
    input  btn_jump, btn_reset, collision, game_tick,
    output game_state, score, high_score, start_pulse
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Game sequencer: button/tick edge detection, INIT/START/END/RESET FSM,
// saturating score counter and session high score.
module game_state_ctrl #(
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int RESET_CYCLES   = 4,
  parameter int SCORE_MAX      = 9999
) (
  input logic              clk,
  input logic              rst,
  game_state_ctrl_if.slave bus
);
  localparam int SCORE_W = 14;
  localparam int LOCK_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int RCNT_W  = $clog2(RESET_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [RCNT_W-1:0]  RCNT_LOAD = RCNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_START = 2'd1,
    ST_END   = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s >= SCORE_SAT) return SCORE_SAT;
    return s + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] max_score(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic jump_sync_p0, jump_sync_p1, jump_edge_p2;
  logic rsb_sync_p0, rsb_sync_p1, rsb_edge_p2;
  logic tick_dly_p0;
  logic jump_press, reset_press, tick;

  state_t             state, state_nx;
  logic [SCORE_W-1:0] score_r, score_nx;
  logic [SCORE_W-1:0] hs_r, hs_nx;
  logic [LOCK_W-1:0]  lock_cnt, lock_nx;
  logic [RCNT_W-1:0]  rcnt, rcnt_nx;
  logic               start_r, start_nx;

  // Stage p0..p2: two-flop synchronizers followed by the edge flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_sync_p0 <= 1'b0;
      jump_sync_p1 <= 1'b0;
      jump_edge_p2 <= 1'b0;
      rsb_sync_p0  <= 1'b0;
      rsb_sync_p1  <= 1'b0;
      rsb_edge_p2  <= 1'b0;
      tick_dly_p0  <= 1'b1;
    end else begin
      jump_sync_p0 <= bus.btn_jump;
      jump_sync_p1 <= jump_sync_p0;
      jump_edge_p2 <= jump_sync_p1;
      rsb_sync_p0  <= bus.btn_reset;
      rsb_sync_p1  <= rsb_sync_p0;
      rsb_edge_p2  <= rsb_sync_p1;
      tick_dly_p0  <= bus.game_tick;
    end
  end

  assign jump_press  = jump_sync_p1 & ~jump_edge_p2;
  assign reset_press = rsb_sync_p1 & ~rsb_edge_p2;
  // game_tick is already in the clk domain, so only an edge detect is needed
  assign tick        = bus.game_tick & ~tick_dly_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      score_r  <= '0;
      hs_r     <= '0;
      lock_cnt <= '0;
      rcnt     <= '0;
      start_r  <= 1'b0;
    end else begin
      state    <= state_nx;
      score_r  <= score_nx;
      hs_r     <= hs_nx;
      lock_cnt <= lock_nx;
      rcnt     <= rcnt_nx;
      start_r  <= start_nx;
    end
  end

  always_comb begin
    state_nx = state;
    score_nx = score_r;
    hs_nx    = hs_r;
    lock_nx  = lock_cnt;
    rcnt_nx  = rcnt;
    start_nx = 1'b0;
    // A reset press outranks everything, including a same-cycle collision
    if (reset_press) begin
      state_nx = ST_RESET;
      rcnt_nx  = RCNT_LOAD;
      score_nx = '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (jump_press) begin
            state_nx = ST_START;
            score_nx = '0;
            start_nx = 1'b1;
          end
        end
        ST_START: begin
          if (bus.collision) begin
            state_nx = ST_END;
            hs_nx    = max_score(hs_r, score_r);
            lock_nx  = LOCK_LOAD;
          end else if (tick) begin
            score_nx = sat_inc(score_r);
          end
        end
        ST_END: begin
          if (lock_cnt == '0) begin
            if (jump_press) begin
              state_nx = ST_RESET;
              rcnt_nx  = RCNT_LOAD;
              score_nx = '0;
            end
          end else begin
            lock_nx = lock_cnt - LOCK_W'(1);
          end
        end
        ST_RESET: begin
          score_nx = '0;
          if (rcnt == '0) state_nx = ST_INIT;
          else            rcnt_nx  = rcnt - RCNT_W'(1);
        end
        default: state_nx = ST_INIT;
      endcase
    end
  end

  assign bus.game_state  = state;
  assign bus.score       = score_r;
  assign bus.high_score  = hs_r;
  assign bus.start_pulse = start_r;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed-plus-random bench for game_state_ctrl; expectations come from
// tick counts, max() of round scores and cycle offsets relative to END entry.
module tb_game_state_ctrl;
  localparam int LOCK = 8;
  localparam int RDW  = 4;
  localparam int SMAX = 9999;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_state_ctrl_if bus();

  game_state_ctrl #(
    .LOCKOUT_CYCLES(LOCK),
    .RESET_CYCLES  (RDW),
    .SCORE_MAX     (SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score = 0;
  int exp_hs    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising edge of game_tick lands on the edge after it is raised
  task automatic do_tick(input int gap);
    bus.game_tick = 1'b0;
    repeat (1 + gap) step();
    bus.game_tick = 1'b1;
    step();
    exp_score = (exp_score + 1 > SMAX) ? SMAX : exp_score + 1;
  endtask

  task automatic start_game();
    bus.btn_jump = 1'b1;
    step();
    bus.btn_jump = 1'b0;
    step();
    check("start_latency", bus.game_state, 0);
    step();
    check("start_state", bus.game_state, 1);
    check("start_pulse_hi", bus.start_pulse, 1);
    exp_score = 0;
    check("start_score", bus.score, 0);
    step();
    check("start_pulse_lo", bus.start_pulse, 0);
  endtask

  task automatic collide(input bit with_tick);
    if (with_tick) begin
      bus.game_tick = 1'b0;
      step();
      bus.game_tick = 1'b1;
    end
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    if (exp_score > exp_hs) exp_hs = exp_score;
    check("collide_state", bus.game_state, 2);
    check("collide_score", bus.score, exp_score);
    check("collide_hs", bus.high_score, exp_hs);
  endtask

  // Entered at END entry; k = edge offset at which the jump level is sampled
  task automatic end_to_reset(input int k_first);
    int t = 0;
    int k = k_first;
    bit done = 0;
    while (!done) begin
      while (t < k - 1) begin
        step();
        t++;
      end
      bus.btn_jump = 1'b1;
      step();
      t++;
      bus.btn_jump = 1'b0;
      step();
      t++;
      check("end_hold", bus.game_state, 2);
      step();
      t++;
      if (t >= LOCK) begin
        check("lockout_accept", bus.game_state, 3);
        done = 1;
      end else begin
        check("lockout_ignore", bus.game_state, 2);
        k = t + 1 + $urandom_range(0, 3);
      end
    end
  endtask

  task automatic dwell();
    check("dwell_first", bus.game_state, 3);
    repeat (RDW - 1) begin
      step();
      check("dwell", bus.game_state, 3);
    end
    step();
    exp_score = 0;
    check("dwell_init", bus.game_state, 0);
    check("dwell_score", bus.score, 0);
    check("dwell_hs", bus.high_score, exp_hs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_jump  = 1'b0;
    bus.btn_reset = 1'b0;
    bus.collision = 1'b0;
    bus.game_tick = 1'b1;

    // Power-up
    repeat (5) @(posedge clk);
    #1;
    check("rst_state", bus.game_state, 0);
    check("rst_score", bus.score, 0);
    check("rst_hs", bus.high_score, 0);
    check("rst_pulse", bus.start_pulse, 0);
    rst = 1'b1;
    repeat (10) begin
      step();
      check("idle_score", bus.score, 0);
      check("idle_state", bus.game_state, 0);
    end

    // First round: 25 ticks with jump held, then collision
    start_game();
    bus.btn_jump = 1'b1;
    for (int i = 0; i < 25; i++) do_tick($urandom_range(0, 2));
    check("score25", bus.score, 25);
    check("held_no_trans", bus.game_state, 1);
    bus.btn_jump = 1'b0;
    step();
    step();
    check("score25_hold", bus.score, exp_score);
    collide(1'b0);
    end_to_reset(3);
    dwell();

    // Second round: 10 ticks, collision and tick together, exact lockout edge
    start_game();
    for (int i = 0; i < 10; i++) do_tick($urandom_range(0, 1));
    check("score10", bus.score, 10);
    collide(1'b1);
    check("hs_kept25", bus.high_score, 25);
    end_to_reset(LOCK - 2);
    dwell();

    // Random rounds
    for (int r = 0; r < 4; r++) begin
      int n;
      start_game();
      n = $urandom_range(1, 60);
      bus.btn_jump = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) do_tick($urandom_range(0, 2));
      bus.btn_jump = 1'b0;
      step();
      step();
      check("rand_score", bus.score, exp_score);
      collide(1'($urandom_range(0, 1)));
      end_to_reset($urandom_range(1, 10));
      dwell();
    end

    // Saturation, then reset press coinciding with collision
    start_game();
    for (int i = 0; i < 10000; i++) do_tick(0);
    check("sat_score", bus.score, SMAX);
    do_tick(0);
    check("sat_hold", bus.score, SMAX);
    bus.btn_reset = 1'b1;
    step();
    bus.btn_reset = 1'b0;
    step();
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("rstcol_state", bus.game_state, 3);
    check("rstcol_hs", bus.high_score, exp_hs);
    dwell();

    // Asynchronous reset mid-START
    start_game();
    for (int i = 0; i < 40; i++) do_tick($urandom_range(0, 1));
    check("score40", bus.score, 40);
    #3;
    rst = 1'b0;
    #1;
    exp_hs = 0;
    exp_score = 0;
    check("async_state", bus.game_state, 0);
    check("async_score", bus.score, 0);
    check("async_hs", bus.high_score, 0);
    check("async_pulse", bus.start_pulse, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("post_async_state", bus.game_state, 0);
    check("post_async_score", bus.score, 0);

    // Jump and reset press together in INIT
    bus.btn_jump  = 1'b1;
    bus.btn_reset = 1'b1;
    step();
    bus.btn_jump  = 1'b0;
    bus.btn_reset = 1'b0;
    step();
    step();
    check("jump_rst_tie", bus.game_state, 3);
    check("jump_rst_pulse", bus.start_pulse, 0);
    dwell();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
